// File: rtl/psum_accum.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accum
//  Purpose  : Pops 8-lane partial-sum vectors from the OFIFO (one per input
//             pixel), maps each pixel onto the output window for the current
//             kernel position and accumulates into the output SRAM:
//             overwrite on kij 0, read-modify-write otherwise, ReLU on the
//             last kernel position. Out-of-window pixels are dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module psum_accum #(
    parameter int COL      = 8,
    parameter int PSUM_BW  = 16,
    parameter int IN_DIM   = 6,
    parameter int KER      = 3,
    parameter int OUT_BASE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               kij,
    output logic                     busy,
    output logic                     done,
    input  logic                     ofifo_valid,
    input  logic [COL*PSUM_BW-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    input  logic [COL*PSUM_BW-1:0]   OP_q,
    output logic [COL*PSUM_BW-1:0]   OP_d,
    output logic [8:0]               OP_addr,
    output logic                     OP_cen,
    output logic                     OP_wen
);

    localparam int c_VW  = COL * PSUM_BW;
    localparam int c_OD  = IN_DIM - KER + 1;
    localparam int c_NK  = KER * KER;
    localparam int c_CW  = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ACC   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [3:0]          r_kij;
    logic [3:0]          r_ki;
    logic [3:0]          r_kj;
    logic [c_CW-1:0]     r_row;
    logic [c_CW-1:0]     r_col;
    logic [c_VW-1:0]     r_hold;
    logic [8:0]          r_addr;
    logic                r_last;

    logic                w_accept;
    logic                w_pop;
    logic                w_last;
    logic                w_kij0;
    logic                w_relu;
    logic [9:0]          w_rz;
    logic [9:0]          w_cz;
    logic [9:0]          w_kiz;
    logic [9:0]          w_kjz;
    logic [9:0]          w_dr;
    logic [9:0]          w_dc;
    logic [9:0]          w_off;
    logic                w_win;
    logic [8:0]          w_addr;
    logic [c_VW-1:0]     w_acc;

    assign w_accept = (r_state == S_IDLE) && start && ({1'b0, kij} < 5'(c_NK));
    assign w_pop    = (r_state == S_FETCH) && ofifo_valid;
    assign w_last   = (r_row == c_CW'(IN_DIM - 1)) && (r_col == c_CW'(IN_DIM - 1));
    assign w_kij0   = (r_kij == 4'd0);
    assign w_relu   = (r_kij == 4'(c_NK - 1));

    // Window test and target address; widened so the subtractions cannot wrap unnoticed
    assign w_rz   = 10'(r_row);
    assign w_cz   = 10'(r_col);
    assign w_kiz  = 10'(r_ki);
    assign w_kjz  = 10'(r_kj);
    assign w_dr   = w_rz - w_kiz;
    assign w_dc   = w_cz - w_kjz;
    assign w_win  = (w_rz >= w_kiz) && (w_dr < 10'(c_OD)) &&
                    (w_cz >= w_kjz) && (w_dc < 10'(c_OD));
    assign w_off  = (w_dr * 10'(c_OD)) + w_dc;
    assign w_addr = 9'(OUT_BASE) + w_off[8:0];

    // Per-lane saturating add of SRAM read data and the held vector, optional ReLU
    for (genvar g = 0; g < COL; g++) begin : g_lane
        logic signed [PSUM_BW:0]   w_sum;
        logic        [PSUM_BW-1:0] w_sat;
        assign w_sum = {OP_q[g*PSUM_BW+PSUM_BW-1], OP_q[g*PSUM_BW +: PSUM_BW]} +
                       {r_hold[g*PSUM_BW+PSUM_BW-1], r_hold[g*PSUM_BW +: PSUM_BW]};
        assign w_sat = (w_sum[PSUM_BW] != w_sum[PSUM_BW-1]) ?
                       (w_sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                       : {1'b0, {(PSUM_BW-1){1'b1}}}) :
                       w_sum[PSUM_BW-1:0];
        assign w_acc[g*PSUM_BW +: PSUM_BW] = (w_relu && w_sat[PSUM_BW-1]) ?
                                             {PSUM_BW{1'b0}} : w_sat;
    end

    // Pass sequencing: latch kernel position, walk pixels, hold RMW operands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_kij   <= 4'd0;
            r_ki    <= 4'd0;
            r_kj    <= 4'd0;
            r_row   <= '0;
            r_col   <= '0;
            r_hold  <= '0;
            r_addr  <= 9'd0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_kij   <= kij;
                        r_ki    <= kij / 4'(KER);
                        r_kj    <= kij % 4'(KER);
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_pop) begin
                        if (r_col == c_CW'(IN_DIM - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_win && !w_kij0) begin
                            r_hold  <= ofifo_out;
                            r_addr  <= w_addr;
                            r_last  <= w_last;
                            r_state <= S_ACC;
                        end else if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ACC: begin
                    r_state <= r_last ? S_DONE : S_FETCH;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // SRAM and pop strobes decoded from state, counters and FIFO head
    always_comb begin
        ofifo_rd = 1'b0;
        OP_cen   = 1'b1;
        OP_wen   = 1'b1;
        OP_addr  = 9'd0;
        OP_d     = '0;
        case (r_state)
            S_FETCH: begin
                ofifo_rd = ofifo_valid;
                if (ofifo_valid && w_win) begin
                    OP_cen  = 1'b0;
                    OP_addr = w_addr;
                    if (w_kij0) begin
                        OP_wen = 1'b0;
                        OP_d   = ofifo_out;
                    end
                end
            end
            S_ACC: begin
                OP_cen  = 1'b0;
                OP_wen  = 1'b0;
                OP_addr = r_addr;
                OP_d    = w_acc;
            end
            default: begin
                ofifo_rd = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_accum
//  Purpose  : Directed bench for psum_accum with a behavioural OFIFO source
//             and single-port SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accum;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   kij = 4'd0;
    logic         busy;
    logic         done;
    logic         ofifo_valid;
    logic [127:0] ofifo_out;
    logic         ofifo_rd;
    logic [127:0] OP_q = '0;
    logic [127:0] OP_d;
    logic [8:0]   OP_addr;
    logic         OP_cen;
    logic         OP_wen;

    logic [127:0] mem [0:511];
    logic         ld_en = 1'b0;
    logic [8:0]   ld_addr = 9'd0;
    logic [127:0] ld_data = '0;

    logic         fifo_en = 1'b0;
    logic         stall_mode = 1'b0;
    logic         phase = 1'b0;
    logic         vmode = 1'b0;
    logic [15:0]  in_val = 16'd0;
    int           pop_base = 0;

    int pops = 0, reads = 0, writes = 0, rd_bad = 0, bad_addr = 0;
    int n_tests = 0, n_fail = 0;
    int last_lat = 0, last_pops = 0, last_reads = 0, last_writes = 0;

    always #5 clk = ~clk;

    psum_accum dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .kij         (kij),
        .busy        (busy),
        .done        (done),
        .ofifo_valid (ofifo_valid),
        .ofifo_out   (ofifo_out),
        .ofifo_rd    (ofifo_rd),
        .OP_q        (OP_q),
        .OP_d        (OP_d),
        .OP_addr     (OP_addr),
        .OP_cen      (OP_cen),
        .OP_wen      (OP_wen)
    );

    function automatic logic [127:0] vec(input logic [15:0] v);
        return {8{v}};
    endfunction

    assign ofifo_valid = fifo_en && (!stall_mode || phase);
    assign ofifo_out   = vec(vmode ? in_val : 16'(pops - pop_base));

    // SRAM model: one-cycle read latency, bench preload port
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (!OP_cen) begin
            if (!OP_wen) mem[OP_addr] <= OP_d;
            else         OP_q <= mem[OP_addr];
        end
    end

    // Activity monitor
    always @(posedge clk) begin
        phase <= ~phase;
        if (ofifo_rd && ofifo_valid)  pops   <= pops + 1;
        if (ofifo_rd && !ofifo_valid) rd_bad <= rd_bad + 1;
        if (!OP_cen && OP_wen)        reads  <= reads + 1;
        if (!OP_cen && !OP_wen) begin
            writes <= writes + 1;
            if (OP_addr > 9'd15) bad_addr <= bad_addr + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] even_v, input logic [15:0] odd_v);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 9'(a);
            ld_data = vec((a % 2 == 0) ? even_v : odd_v);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_pass(input string tag, input logic [3:0] k, input bit vm,
                            input logic [15:0] val, input bit stall, input bit poke);
        int p0, r0, w0, n;
        p0 = pops; r0 = reads; w0 = writes;
        vmode = vm; in_val = val; stall_mode = stall;
        pop_base = pops;
        @(negedge clk);
        start = 1'b1; kij = k; fifo_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'd1);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            if (poke && n == 10) begin start = 1'b1; kij = 4'd0; end
            else start = 1'b0;
        end
        chk({tag, "_done_seen"}, 128'(done), 128'd1);
        @(negedge clk);
        chk({tag, "_idle_after"}, 128'(busy), 128'd0);
        fifo_en = 1'b0; stall_mode = 1'b0;
        last_lat = n; last_pops = pops - p0;
        last_reads = reads - r0; last_writes = writes - w0;
    endtask

    initial begin
        int found, n, b_any, d_any, p0;

        // Reset state
        #1;
        chk("rst_ofifo_rd", 128'(ofifo_rd), 128'd0);
        chk("rst_cen",      128'(OP_cen),   128'd1);
        chk("rst_wen",      128'(OP_wen),   128'd1);
        chk("rst_addr",     128'(OP_addr),  128'd0);
        chk("rst_d",        OP_d,           128'd0);
        chk("rst_busy",     128'(busy),     128'd0);
        chk("rst_done",     128'(done),     128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // kij=0: overwrite with pixel index, 16 writes, no reads
        preload(16'hDEAD, 16'hDEAD);
        run_pass("k0", 4'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        chk("k0_lat",    128'(last_lat),    128'd36);
        chk("k0_pops",   128'(last_pops),   128'd36);
        chk("k0_reads",  128'(last_reads),  128'd0);
        chk("k0_writes", 128'(last_writes), 128'd16);
        chk("k0_badaddr", 128'(bad_addr),   128'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("k0_w%0d", r*4+c), mem[r*4+c], vec(16'(r*6+c)));

        // kij=4: 100 + 1 everywhere in the window
        preload(16'd100, 16'd100);
        run_pass("k4", 4'd4, 1'b1, 16'd1, 1'b0, 1'b0);
        chk("k4_lat",    128'(last_lat),    128'd52);
        chk("k4_pops",   128'(last_pops),   128'd36);
        chk("k4_reads",  128'(last_reads),  128'd16);
        chk("k4_writes", 128'(last_writes), 128'd16);
        for (int a = 0; a < 16; a++) chk($sformatf("k4_w%0d", a), mem[a], vec(16'd101));

        // Saturation at both rails
        preload(16'h7FF8, 16'h7FF8);
        run_pass("satp", 4'd2, 1'b1, 16'd100, 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) chk($sformatf("satp_w%0d", a), mem[a], vec(16'h7FFF));
        preload(16'h8008, 16'h8008);
        run_pass("satn", 4'd2, 1'b1, 16'hFF9C, 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) chk($sformatf("satn_w%0d", a), mem[a], vec(16'h8000));

        // ReLU on kij=8: -50+10 -> 0, 50+10 -> 60; last pixel needs ACC
        preload(16'hFFCE, 16'd50);
        run_pass("k8", 4'd8, 1'b1, 16'd10, 1'b0, 1'b0);
        chk("k8_lat", 128'(last_lat), 128'd52);
        for (int a = 0; a < 16; a++)
            chk($sformatf("k8_w%0d", a), mem[a], vec((a % 2 == 0) ? 16'd0 : 16'd60));
        preload(16'hFFCE, 16'hFFCE);
        run_pass("k7", 4'd7, 1'b1, 16'd10, 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) chk($sformatf("k7_w%0d", a), mem[a], vec(16'hFFD8));

        // Backpressure plus a start pulse while busy
        preload(16'd100, 16'd100);
        p0 = rd_bad;
        run_pass("bp", 4'd4, 1'b1, 16'd1, 1'b1, 1'b1);
        chk("bp_pops",   128'(last_pops), 128'd36);
        chk("bp_rd_bad", 128'(rd_bad - p0), 128'd0);
        for (int a = 0; a < 16; a++) chk($sformatf("bp_w%0d", a), mem[a], vec(16'd101));

        // Out-of-range kernel index is ignored
        p0 = pops; b_any = 0; d_any = 0;
        @(negedge clk);
        fifo_en = 1'b1; start = 1'b1; kij = 4'd9;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy) b_any = 1;
            if (done) d_any = 1;
            @(negedge clk);
        end
        fifo_en = 1'b0;
        chk("k9_busy", 128'(b_any), 128'd0);
        chk("k9_done", 128'(d_any), 128'd0);
        chk("k9_pops", 128'(pops - p0), 128'd0);

        // Asynchronous reset while in the ACC half of a read-modify-write
        preload(16'd100, 16'd100);
        vmode = 1'b1; in_val = 16'd1;
        @(negedge clk);
        start = 1'b1; kij = 4'd4; fifo_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0; n = 0;
        while (!found && n < 50) begin
            if (!OP_cen && !OP_wen) found = 1;
            else begin @(negedge clk); n++; end
        end
        chk("acc_reached", 128'(found), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("acc_rst_cen",  128'(OP_cen), 128'd1);
        chk("acc_rst_wen",  128'(OP_wen), 128'd1);
        chk("acc_rst_busy", 128'(busy),   128'd0);
        fifo_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_pass("post", 4'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        chk("post_lat",  128'(last_lat),  128'd36);
        chk("post_pops", 128'(last_pops), 128'd36);
        chk("post_w0",   mem[0],  vec(16'd0));
        chk("post_w5",   mem[5],  vec(16'd7));
        chk("post_w15",  mem[15], vec(16'd21));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
